// File: rtl/fp_mul_seq_pkg.sv
// Shared definitions for the sequential binary32 multiply core and its
// round/pack stage: default geometry, special-value patterns, FSM states.
package fp_mul_seq_pkg;

    localparam int DEF_EXP_WIDTH      = 8;
    localparam int DEF_FRAC_WIDTH     = 24;
    localparam int DEF_BITS_PER_CYCLE = 4;
    localparam int DEF_BIAS           = (1 << (DEF_EXP_WIDTH - 1)) - 1;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] INF  = 32'h7F80_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        ROUND = 2'd2
    } state_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
    } fp_class_t;

    // Subnormals are treated as zero, so a zero exponent field alone means zero.
    function automatic fp_class_t classify(input logic exp_ones, input logic exp_zero,
                                           input logic frac_nz);
        fp_class_t c;
        c.nan  = exp_ones & frac_nz;
        c.inf  = exp_ones & ~frac_nz;
        c.zero = exp_zero;
        return c;
    endfunction

endpackage

// File: rtl/fp_mul_seq_round_pack.sv
// Combinational normalize, round-to-nearest-even and pack of an exact
// significand product, with special-value override. Shared with the fadd core.
module fp_mul_seq_round_pack
    import fp_mul_seq_pkg::*;
#(
    parameter int EXP_WIDTH  = DEF_EXP_WIDTH,
    parameter int FRAC_WIDTH = DEF_FRAC_WIDTH
) (
    input  logic                             sign,
    input  logic signed [EXP_WIDTH+1:0]      exp_sum,
    input  logic [2*FRAC_WIDTH-1:0]          prod,
    input  logic                             any_nan,
    input  logic                             any_inf,
    input  logic                             any_zero,
    output logic [EXP_WIDTH+FRAC_WIDTH-1:0]  packed_word
);

    localparam int W   = EXP_WIDTH + FRAC_WIDTH;
    localparam int F   = FRAC_WIDTH;
    localparam int PW  = 2 * FRAC_WIDTH;
    localparam int EW2 = EXP_WIDTH + 2;
    localparam bit IS_DEF = (EXP_WIDTH == DEF_EXP_WIDTH) && (FRAC_WIDTH == DEF_FRAC_WIDTH);

    localparam logic [W-1:0] QNAN_W = IS_DEF ? W'(QNAN)
                                             : {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(F-2){1'b0}}};
    localparam logic [W-1:0] INF_W  = IS_DEF ? W'(INF)
                                             : {1'b0, {EXP_WIDTH{1'b1}}, {(F-1){1'b0}}};
    localparam logic signed [EW2-1:0] EXP_ONE  = EW2'(1);
    localparam logic signed [EW2-1:0] EXP_ZERO = EW2'(0);
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_WIDTH) - 1);

    logic [F-2:0]            frac_s;
    logic                    guard_s;
    logic                    sticky_s;
    logic                    round_up_s;
    logic [F-1:0]            rnd_s;
    logic signed [EW2-1:0]   exp_n_s;
    logic signed [EW2-1:0]   exp_f_s;

    // Normalize, round, then pick between special values and the finite result.
    always_comb begin
        frac_s      = '0;
        guard_s     = 1'b0;
        sticky_s    = 1'b0;
        exp_n_s     = exp_sum;
        packed_word = '0;
        // The hidden bit is never stored, so only the bits below it are taken.
        if (prod[PW-1]) begin
            frac_s   = prod[PW-2 -: F-1];
            guard_s  = prod[F-1];
            sticky_s = |prod[F-2:0];
            exp_n_s  = exp_sum + EXP_ONE;
        end else begin
            frac_s   = prod[PW-3 -: F-1];
            guard_s  = prod[F-2];
            sticky_s = |prod[F-3:0];
            exp_n_s  = exp_sum;
        end
        round_up_s = guard_s & (sticky_s | frac_s[0]);
        // A carry out of the fraction leaves it all zeros: significand 1.0, exponent +1.
        rnd_s   = {1'b0, frac_s} + {{(F-1){1'b0}}, round_up_s};
        exp_f_s = exp_n_s + (rnd_s[F-1] ? EXP_ONE : EXP_ZERO);

        if (any_nan || (any_inf && any_zero)) begin
            packed_word = QNAN_W;
        end else if (any_inf) begin
            packed_word = {sign, INF_W[W-2:0]};
        end else if (any_zero) begin
            packed_word = {sign, {(W-1){1'b0}}};
        end else if (exp_f_s >= EXP_MAX) begin
            packed_word = {sign, INF_W[W-2:0]};
        end else if (exp_f_s <= EXP_ZERO) begin
            packed_word = {sign, {(W-1){1'b0}}};
        end else begin
            packed_word = {sign, exp_f_s[EXP_WIDTH-1:0], rnd_s[F-2:0]};
        end
    end

endmodule

// File: rtl/fp_mul_seq.sv
// Multi-cycle binary32 multiplier: iterative shift-add significand product,
// then a two-cycle round/publish stage so every operation takes a fixed 8 cycles.
module fp_mul_seq
    import fp_mul_seq_pkg::*;
#(
    parameter int EXP_WIDTH      = DEF_EXP_WIDTH,
    parameter int FRAC_WIDTH     = DEF_FRAC_WIDTH,
    parameter int BITS_PER_CYCLE = DEF_BITS_PER_CYCLE
) (
    input  logic                            clkIn,
    input  logic                            rstLowIn,
    input  logic [EXP_WIDTH+FRAC_WIDTH-1:0] dataAIn,
    input  logic [EXP_WIDTH+FRAC_WIDTH-1:0] dataBIn,
    input  logic                            validIn,
    output logic [EXP_WIDTH+FRAC_WIDTH-1:0] dataOut,
    output logic                            validOut,
    output logic                            busyOut
);

    localparam int W     = EXP_WIDTH + FRAC_WIDTH;
    localparam int F     = FRAC_WIDTH;
    localparam int PW    = 2 * FRAC_WIDTH;
    localparam int EW2   = EXP_WIDTH + 2;
    localparam int ITERS = FRAC_WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int BIAS  = (EXP_WIDTH == DEF_EXP_WIDTH) ? DEF_BIAS
                                                        : (1 << (EXP_WIDTH - 1)) - 1;
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(BIAS);

    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [PW-1:0]          ma_r;
    logic [F-1:0]           mb_r;
    logic [PW-1:0]          prod_r;
    logic                   sign_r;
    logic signed [EW2-1:0]  exp_r;
    logic                   any_nan_r;
    logic                   any_inf_r;
    logic                   any_zero_r;
    logic                   round_phase_r;
    logic [W-1:0]           res_r;
    logic [W-1:0]           data_r;
    logic                   valid_r;
    logic                   busy_r;

    logic [EXP_WIDTH-1:0]   exp_a_s;
    logic [EXP_WIDTH-1:0]   exp_b_s;
    logic [F-2:0]           frac_a_s;
    logic [F-2:0]           frac_b_s;
    fp_class_t              cls_a_s;
    fp_class_t              cls_b_s;
    logic signed [EW2-1:0]  exp_sum_s;
    logic [PW-1:0]          pp_s;
    logic [W-1:0]           pack_s;

    // Operand unpack, classification and biased exponent sum for the accept cycle.
    always_comb begin
        exp_a_s   = dataAIn[W-2 -: EXP_WIDTH];
        exp_b_s   = dataBIn[W-2 -: EXP_WIDTH];
        frac_a_s  = dataAIn[F-2:0];
        frac_b_s  = dataBIn[F-2:0];
        cls_a_s   = classify(&exp_a_s, ~|exp_a_s, |frac_a_s);
        cls_b_s   = classify(&exp_b_s, ~|exp_b_s, |frac_b_s);
        exp_sum_s = $signed({2'b00, exp_a_s}) + $signed({2'b00, exp_b_s}) - BIAS_S;
    end

    // Sum of this cycle's partial products; the multiplicand is pre-shifted each cycle.
    always_comb begin
        pp_s = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mb_r[i]) begin
                pp_s = pp_s + (ma_r << i);
            end else begin
                pp_s = pp_s;
            end
        end
    end

    fp_mul_seq_round_pack #(
        .EXP_WIDTH  (EXP_WIDTH),
        .FRAC_WIDTH (FRAC_WIDTH)
    ) u_round_pack (
        .sign        (sign_r),
        .exp_sum     (exp_r),
        .prod        (prod_r),
        .any_nan     (any_nan_r),
        .any_inf     (any_inf_r),
        .any_zero    (any_zero_r),
        .packed_word (pack_s)
    );

    // Control FSM and datapath registers; ROUND registers the packed word, then publishes it.
    always_ff @(posedge clkIn) begin
        if (!rstLowIn) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            ma_r          <= '0;
            mb_r          <= '0;
            prod_r        <= '0;
            sign_r        <= 1'b0;
            exp_r         <= '0;
            any_nan_r     <= 1'b0;
            any_inf_r     <= 1'b0;
            any_zero_r    <= 1'b0;
            round_phase_r <= 1'b0;
            res_r         <= '0;
            data_r        <= '0;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    valid_r <= 1'b0;
                    if (validIn) begin
                        ma_r       <= {{F{1'b0}}, |exp_a_s, frac_a_s};
                        mb_r       <= {|exp_b_s, frac_b_s};
                        prod_r     <= '0;
                        sign_r     <= dataAIn[W-1] ^ dataBIn[W-1];
                        exp_r      <= exp_sum_s;
                        any_nan_r  <= cls_a_s.nan | cls_b_s.nan;
                        any_inf_r  <= cls_a_s.inf | cls_b_s.inf;
                        any_zero_r <= cls_a_s.zero | cls_b_s.zero;
                        cnt_r      <= CNT_W'(ITERS - 1);
                        busy_r     <= 1'b1;
                        state_r    <= MULT;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                MULT: begin
                    prod_r <= prod_r + pp_s;
                    ma_r   <= ma_r << BITS_PER_CYCLE;
                    mb_r   <= mb_r >> BITS_PER_CYCLE;
                    if (cnt_r == '0) begin
                        round_phase_r <= 1'b0;
                        state_r       <= ROUND;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                ROUND: begin
                    if (!round_phase_r) begin
                        res_r         <= pack_s;
                        round_phase_r <= 1'b1;
                    end else begin
                        data_r        <= res_r;
                        valid_r       <= 1'b1;
                        round_phase_r <= 1'b0;
                        state_r       <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign dataOut  = data_r;
    assign validOut = valid_r;
    assign busyOut  = busy_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed special/rounding cases, a reset
// mid-operation, and a back-to-back chain of random operands against a reference model.
module tb_fp_mul_seq;

    logic        clkIn = 1'b0;
    logic        rstLowIn = 1'b0;
    logic        validIn = 1'b0;
    logic [31:0] dataAIn = 32'd0;
    logic [31:0] dataBIn = 32'd0;
    logic [31:0] dataOut;
    logic        validOut;
    logic        busyOut;

    int tests = 0;
    int fails = 0;

    fp_mul_seq dut (
        .clkIn    (clkIn),
        .rstLowIn (rstLowIn),
        .dataAIn  (dataAIn),
        .dataBIn  (dataBIn),
        .validIn  (validIn),
        .dataOut  (dataOut),
        .validOut (validOut),
        .busyOut  (busyOut)
    );

    always #5 clkIn = ~clkIn;

    // Exact product of the two significands, then round the real value to 24 bits.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, e, sh;
        logic s;
        logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        longint unsigned ma, mb, p, q, rem, half;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        nan_a = (ea == 255) && (a[22:0] != 23'd0);
        nan_b = (eb == 255) && (b[22:0] != 23'd0);
        inf_a = (ea == 255) && (a[22:0] == 23'd0);
        inf_b = (eb == 255) && (b[22:0] == 23'd0);
        zero_a = (ea == 0);
        zero_b = (eb == 0);
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) return 32'h7FC0_0000;
        if (inf_a || inf_b) return {s, 31'h7F80_0000};
        if (zero_a || zero_b) return {s, 31'd0};
        ma = 64'h80_0000 + 64'(a[22:0]);
        mb = 64'h80_0000 + 64'(b[22:0]);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
        else sh = 23;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin q = 64'd1 << 23; e = e + 1; end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [7:0] e;
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7) e = 8'($urandom_range(90, 165));
        else if (sel == 7) e = 8'd0;
        else if (sel == 8) e = 8'hFF;
        else e = 8'($urandom);
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dataAIn = a;
        dataBIn = b;
        validIn = 1'b1;
        @(negedge clkIn);
        validIn = 1'b0;
        dataAIn = $urandom();
        dataBIn = $urandom();
    endtask

    // Called one negedge after the accepting edge; optionally pokes validIn mid-op
    // and optionally starts the next operation in the validOut cycle.
    task automatic await_result(input logic [31:0] expv, input string tag, input bit poke,
                                input bit chain, input logic [31:0] na, input logic [31:0] nb);
        int cnt = 0;
        bit busy_ok = 1'b1;
        while (validOut !== 1'b1 && cnt < 20) begin
            if (busyOut !== 1'b1) busy_ok = 1'b0;
            if (poke && cnt == 3) begin
                validIn = 1'b1;
                dataAIn = $urandom();
                dataBIn = $urandom();
            end else begin
                validIn = 1'b0;
            end
            @(negedge clkIn);
            cnt++;
        end
        validIn = 1'b0;
        chk({tag, " latency"}, 32'(cnt), 32'd8);
        chk({tag, " busy"}, {31'd0, busy_ok & busyOut}, 32'd1);
        chk({tag, " data"}, dataOut, expv);
        if (chain) begin
            dataAIn = na;
            dataBIn = nb;
            validIn = 1'b1;
        end
        @(negedge clkIn);
        validIn = 1'b0;
        chk({tag, " pulse"}, {31'd0, validOut}, 32'd0);
        chk({tag, " hold"}, dataOut, expv);
        if (!chain) chk({tag, " idle"}, {31'd0, busyOut}, 32'd0);
    endtask

    logic [31:0] da [10] = '{32'h3FC00000, 32'hC0400000, 32'h3F800001, 32'h3F800003, 32'h7F000000,
                             32'h00800000, 32'h80400000, 32'h7F800000, 32'hFF800000, 32'h7FA00000};
    logic [31:0] db [10] = '{32'h40000000, 32'h3F000000, 32'h3F800001, 32'h3F800003, 32'h7F000000,
                             32'h00800000, 32'h3F800000, 32'h00000000, 32'h40000000, 32'h3F800000};
    logic [31:0] de [10] = '{32'h40400000, 32'hBFC00000, 32'h3F800002, 32'h3F800006, 32'h7F800000,
                             32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000, 32'h7FC00000};
    logic [31:0] ra [25];
    logic [31:0] rb [25];

    initial begin
        int extra;
        rstLowIn = 1'b0;
        repeat (3) @(negedge clkIn);
        chk("reset data", dataOut, 32'd0);
        chk("reset valid", {31'd0, validOut}, 32'd0);
        chk("reset busy", {31'd0, busyOut}, 32'd0);
        rstLowIn = 1'b1;
        @(negedge clkIn);

        for (int i = 0; i < 10; i++) begin
            launch(da[i], db[i]);
            await_result(de[i], $sformatf("dir%0d", i), i == 1, 1'b0, 32'd0, 32'd0);
            if (i == 1) begin
                extra = 0;
                repeat (10) begin
                    @(negedge clkIn);
                    if (validOut === 1'b1) extra++;
                end
                chk("busy ignore", 32'(extra), 32'd0);
            end
        end

        for (int k = 0; k < 25; k++) begin
            ra[k] = rand_op();
            rb[k] = rand_op();
        end
        launch(ra[0], rb[0]);
        for (int k = 0; k < 24; k++) begin
            await_result(ref_mul(ra[k], rb[k]), $sformatf("rnd%0d", k), 1'b0, k < 23,
                         ra[k+1], rb[k+1]);
        end

        launch(32'h3FC00000, 32'h40000000);
        repeat (2) @(negedge clkIn);
        rstLowIn = 1'b0;
        @(negedge clkIn);
        rstLowIn = 1'b1;
        chk("midrst valid", {31'd0, validOut}, 32'd0);
        chk("midrst data", dataOut, 32'd0);
        chk("midrst busy", {31'd0, busyOut}, 32'd0);
        launch(32'hC0400000, 32'h3F000000);
        await_result(32'hBFC00000, "after rst", 1'b0, 1'b0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
Name: fp_mul_seq

Overview:
- Multi-cycle IEEE-754 binary32 multiply core.
- Sits directly downstream of the fmul.s PCPI decode/handshake stage. That stage registers rs1/rs2 and pulses a start strobe into this core. It then uses this core's done pulse to raise pcpi_ready/pcpi_wr.
- Datapath: iterative shift-add significand multiply, then normalize, round-to-nearest-even and pack.
- Subnormals flush to zero.

Parameters:
- EXP_WIDTH, 8: exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- FRAC_WIDTH, 24: significand width including hidden bit; stored fraction = FRAC_WIDTH-1 bits.
- BITS_PER_CYCLE, 4: multiplier bits retired per MULT cycle; must divide FRAC_WIDTH.

Ports:
- clkIn  in  1  clock; all state changes on rising edge.
- rstLowIn  in  1  synchronous, active-low reset.
- dataAIn  in  EXP_WIDTH+FRAC_WIDTH  operand A (sign|exp|frac).
- dataBIn  in  EXP_WIDTH+FRAC_WIDTH  operand B.
- validIn  in  1  start strobe; sampled only when not busy.
- dataOut  out  EXP_WIDTH+FRAC_WIDTH  packed product; held until next result.
- validOut  out  1  single-cycle done pulse.
- busyOut  out  1  high from accept until validOut cycle inclusive.

Behaviour:
- Reset: rstLowIn=0 at an edge forces state IDLE, dataOut=0, validOut=0, busyOut=0, and clears the accumulator. This applies in any state; an in-flight operation is discarded with no validOut.
- States: IDLE, MULT, ROUND.
  - IDLE, validIn=1: latch and unpack operands, classify (zero/sub, normal, inf, NaN), compute sign=sA^sB, compute expSum=eA+eB-bias in EXP_WIDTH+2 signed bits, clear product, load iteration counter=FRAC_WIDTH/BITS_PER_CYCLE-1. Go to MULT; busyOut=1.
  - MULT: each cycle add BITS_PER_CYCLE partial products (multiplier LSBs first), shift multiplier right. Leave when counter=0, then go to ROUND.
  - ROUND: normalize, round, apply specials, register dataOut. validOut=1 for the next cycle only. Return to IDLE.
- validIn while busy: ignored, no queueing.
- validIn in the same cycle validOut is high: accepted, because the state is already IDLE. This gives back-to-back throughput of one result per L cycles.
- Latency L = FRAC_WIDTH/BITS_PER_CYCLE + 2 = 8 with defaults. validOut is high in the cycle after the 8th rising edge following the edge that sampled validIn. Latency is fixed for all operand classes, special cases included.
- Product is 2*FRAC_WIDTH bits, exact.
  - If bit[2*FRAC_WIDTH-1] is set: shift right 1, exp+1.
  - Guard = first dropped bit; sticky = OR of remaining dropped bits.
  - RNE: increment if guard & (sticky | lsb).
  - Rounding carry-out: significand becomes 1.0, exp+1.
- Final exp >= 2^EXP_WIDTH-1: signed infinity. No max-finite saturation.
- Final exp <= 0: signed zero (FTZ).
- Specials, highest priority first:
  1. Any NaN input, or inf*zero: canonical qNaN 0x7FC00000 (sign 0, frac MSB set).
  2. Inf*nonzero: signed inf.
  3. Zero/subnormal*finite: signed zero.
- dataOut changes only on the ROUND->IDLE edge or on reset.

Decomposition:
- Shared include fp_defs.vh holds:
  - localparams EXP_WIDTH/FRAC_WIDTH defaults and derived BIAS;
  - QNAN and INF bit patterns;
  - state encodings IDLE=2'd0, MULT=2'd1, ROUND=2'd2.
- One natural sub-module: fp_round_pack, purely combinational. Inputs: sign, signed exponent, raw product, special-class flags. Output: packed word. This makes it reusable by the planned fadd.s core.

Test Plan:
- 0x3FC00000 (1.5) * 0x40000000 (2.0), validIn one cycle -> validOut exactly 8 cycles later, dataOut=0x40400000, busyOut high throughout.
- 0xC0400000 (-3) * 0x3F000000 (0.5) -> 0xBFC00000. Second validIn pulsed during MULT -> ignored, exactly one validOut.
- Rounding: 0x3F800001 * 0x3F800001 -> 0x3F800002. Then 0x3F800003 * 0x3F800003 -> 0x3F800006.
- Overflow/underflow:
  - 0x7F000000 * 0x7F000000 -> 0x7F800000.
  - 0x00800000 * 0x00800000 -> 0x00000000.
  - 0x80400000 (neg subnormal) * 0x3F800000 -> 0x80000000.
- Specials:
  - 0x7F800000 * 0x00000000 -> 0x7FC00000.
  - 0xFF800000 * 0x40000000 -> 0xFF800000.
  - 0x7FA00000 (sNaN) * 0x3F800000 -> 0x7FC00000.
- Reset mid-op: start a multiply, drive rstLowIn=0 for one edge at cycle 3 -> validOut never pulses, dataOut=0, busyOut=0. A new validIn on the first cycle after release is accepted with full 8-cycle latency. Back-to-back: validIn asserted during the validOut cycle -> second result exactly 8 cycles later.
